// File: rtl/core_pkg.sv
// Shared definitions for the core front end: instruction encodings, field
// bit positions and the fetch FSM state type.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd1;
  localparam logic [5:0] OP_SW    = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd3;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory req/ack port plus the
// decoded-instruction handshake towards the controller / register file.
//   master : fetch unit side (drives req/addr and the decoded fields)
//   slave  : memory + downstream datapath side
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic              br_taken;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, func, imm,
           pc, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, br_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, func, imm,
           pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, br_taken
  );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC adder: pc + 4, or pc + 4 + (sign-extended imm << 2) on a taken
// branch. Purely combinational; wraps modulo 2^ADDR_W.
// Ports:
//   pc       in   current PC
//   imm      in   16-bit branch offset in words (two's complement)
//   br_taken in   select branch target
//   pc_next  out  next PC
module pc_next_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              br_taken,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    offset = '0;
    if (br_taken) begin
      offset = ADDR_W'($signed(imm)) << 2;
    end
    pc_next = pc + ADDR_W'(4) + offset;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches one 32-bit word per instruction over
// the imem req/ack port, holds it in IR and presents decoded fields until the
// datapath accepts it. A fetch that goes unacknowledged for TIMEOUT cycles
// raises a sticky fetch_err that only reset clears.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  master modport: imem_req/addr/ack/rdata, instr_valid/ready,
//        br_taken, opcode/rs/rt/rd/func/imm, pc, fetch_err
//
// state    | meaning
// ST_FETCH | request outstanding at pc, waiting for imem_ack
// ST_HOLD  | IR valid, waiting for downstream instr_ready
// ST_ERROR | fetch timed out; parked until reset
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input logic             clk,
  input logic             rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC & ~ADDR_W'(3);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [31:0]       ir_q;
  logic [TMR_W-1:0]  timer_q;
  logic              valid_q;
  logic              err_q;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc_q),
    .imm      (ir_q[IMM_MSB:IMM_LSB]),
    .br_taken (bus.br_taken),
    .pc_next  (pc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          // ack takes priority over the timeout threshold in the same cycle
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            timer_q <= '0;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= ST_ERROR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            pc_q    <= pc_next;
            valid_q <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ST_FETCH;
        end
      endcase
    end
  end

  // State already sits at FETCH during reset, so gate with rst to keep the
  // request low until release and high from the very first cycle after.
  assign bus.imem_req    = (state == ST_FETCH) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_err   = err_q;

  assign bus.opcode = ir_q[OPC_MSB:OPC_LSB];
  assign bus.rs     = ir_q[RS_MSB:RS_LSB];
  assign bus.rt     = ir_q[RT_MSB:RT_LSB];
  assign bus.rd     = ir_q[RD_MSB:RD_LSB];
  assign bus.func   = ir_q[FN_MSB:FN_LSB];
  assign bus.imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule
